esfa_op_sequencer: RTL and testbench
====================================

# esfa_op_sequencer

Command sequencer directly upstream of the MemoryCell array. Accepts one high-level ESFA command at a time over a valid/ready handshake and expands it into one or two selector steps broadcast to every cell. It captures the reduced array result (bool/value/context) one cycle after each step and returns a single response per command. Two-step commands chain the first step's result into the second step's metadata.

## Interface
Parameters: none. Widths are fixed at 8 bits to match the cell array.

Ports:
- clk  in  1  rising-edge clock, shared with the cell array
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  opcode: 0 UPDATE, 1 LOOKUP, 2 ENCODE, 3 CONGRUE, 4 ENRANK, 5–7 illegal
- cmd_handle, cmd_index, cmd_value, cmd_metadata  in  8 each  command operands
- cmd_is_metadata  in  1  operand flag forwarded to cells
- cell_selector  out  8  broadcast selector
- cell_will_write  out  1  broadcast write enable
- cell_handle, cell_inserted_index, cell_inserted_value, cell_metadata  out  8 each  broadcast operands
- cell_is_metadata  out  1  broadcast flag
- arr_bool  in  1  reduced cell bool (OR of cells), combinational from cell outputs
- arr_value, arr_context  in  8 each  reduced value/context of the winning cell
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_bool  out  1  result flag
- rsp_value, rsp_context  out  8 each  result payload

## Operation
- Step selectors: update 0, lookUp 1, encode 2, congrueUp 3, congrueDown 4, markAvailableCell 5, enrank 6. Idle selector is 8'hFF, which matches no cell branch, so all cells hold.
- UPDATE has two steps. Step 1 is markAvailableCell with will_write 0. If step 1 arr_bool=0, the command aborts with rsp_bool=0, rsp_value=0, rsp_context=8'hFF (array full), and step 2 is not issued. Step 2 is update with will_write 1, cell_metadata=step-1 arr_context, and cell_is_metadata=1.
- LOOKUP, ENCODE and ENRANK are single steps (selectors 1, 2, 6) with will_write 0.
- CONGRUE has two steps: congrueUp with will_write 1, then congrueDown with will_write 1. Both steps use the command operands unchanged. The response comes from step 2.
- Illegal opcodes produce no cell activity. The response is rsp_bool=0, rsp_value=0, rsp_context=8'hFF.
- All other operands are taken from the command register, which is latched at acceptance and stable for the whole command.

## Timing
- FSM states: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP.
- IDLE → ISSUE1 on cmd_valid&&cmd_ready. For an illegal opcode, IDLE → RESP instead.
- ISSUE1 → WAIT1 always.
- WAIT1 → ISSUE2 for a two-step op that is not aborted; otherwise WAIT1 → RESP.
- ISSUE2 → WAIT2 → RESP.
- RESP → IDLE on rsp_ready.
- cmd_ready=1 only in IDLE.
- All cell_* outputs are registered. The step's selector, will_write and operands are valid only during ISSUEx. In every other state, selector is 8'hFF and will_write is 0.
- The cells register on the ISSUEx edge. arr_* is sampled at the end of WAITx.
- Latency from the accept edge to rsp_valid: single-step 3 cycles; two-step 5 cycles; aborted UPDATE 3 cycles; illegal 1 cycle.
- rsp_* is registered and stays stable while rsp_valid=1 && rsp_ready=0. The next command is accepted no earlier than the cycle after the response handshake.
- Reset values: cmd_ready=0 during reset, 1 in the first cycle after. rsp_valid=0, rsp_bool=0, rsp_value=0, rsp_context=0, cell_selector=8'hFF, cell_will_write=0, all cell operands 0, state IDLE.
- Reset mid-command: the command is dropped and no response is produced. A write already issued to the cells is not undone, because the cells have no reset.

## Structure
- Shared package esfa_pkg contains:
  - selector constants SEL_UPDATE…SEL_ENRANK and SEL_IDLE=8'hFF
  - opcode constants OP_UPDATE…OP_ENRANK
  - CTX_FAIL=8'hFF
  - the state encoding
- Single module; no sub-module is needed. The array-side OR/priority reduction producing arr_* lives outside this block.

## Test plan
- LOOKUP handle 8'h03, array stub returns bool=1, value=8'h2A, context=8'h05 in WAIT1 → selector 1 for exactly one cycle with will_write=0; rsp 1/2A/05 valid 3 cycles after accept.
- UPDATE with the stub answering step 1 bool=1, context=8'h07 → step 2 selector 0, will_write=1, cell_metadata=8'h07, is_metadata=1; rsp_valid 5 cycles after accept.
- UPDATE with step 1 bool=0 → no selector-0 cycle, will_write never asserted; rsp 0/00/FF after 3 cycles.
- CONGRUE → selector sequence 3 then 4, each one cycle with will_write=1 and 8'hFF between steps; response equals the step-2 stub values.
- cmd_op=7 → no non-FF selector; rsp 0/00/FF the next cycle. Hold rsp_ready=0 for 4 cycles → rsp stable and cmd_ready=0 throughout.
- Assert reset in WAIT1 of an UPDATE → next cycle state IDLE, selector FF, rsp_valid=0, cmd_ready=1 after reset deasserts; a following LOOKUP completes normally.

Source files
------------

// File: rtl/esfa_pkg.sv
// ---------------------------------------------------------------------------
// esfa_pkg
// Shared constants for the ESFA command sequencer and the MemoryCell array it
// drives: cell-step selector codes, command opcodes, the "array full /
// failed" context marker and the sequencer state encoding.  A few small
// helper functions decode the opcode so the sequencer stays readable.
// ---------------------------------------------------------------------------
package esfa_pkg;

   localparam int DATA_W = 8;

   // Selector codes broadcast to every cell; SEL_IDLE matches no cell branch
   localparam logic [7:0] SEL_UPDATE       = 8'd0;
   localparam logic [7:0] SEL_LOOKUP       = 8'd1;
   localparam logic [7:0] SEL_ENCODE       = 8'd2;
   localparam logic [7:0] SEL_CONGRUE_UP   = 8'd3;
   localparam logic [7:0] SEL_CONGRUE_DOWN = 8'd4;
   localparam logic [7:0] SEL_MARK_AVAIL   = 8'd5;
   localparam logic [7:0] SEL_ENRANK       = 8'd6;
   localparam logic [7:0] SEL_IDLE         = 8'hFF;

   // High-level command opcodes; 5..7 are illegal
   localparam logic [2:0] OP_UPDATE  = 3'd0;
   localparam logic [2:0] OP_LOOKUP  = 3'd1;
   localparam logic [2:0] OP_ENCODE  = 3'd2;
   localparam logic [2:0] OP_CONGRUE = 3'd3;
   localparam logic [2:0] OP_ENRANK  = 3'd4;

   localparam logic [7:0] CTX_FAIL = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE1 = 3'd1,
      ST_WAIT1  = 3'd2,
      ST_ISSUE2 = 3'd3,
      ST_WAIT2  = 3'd4,
      ST_RESP   = 3'd5
   } state_t;

   // Opcodes above ENRANK have no cell expansion
   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= OP_ENRANK);
   endfunction

   // UPDATE and CONGRUE expand into two cell steps
   function automatic logic is_two_step(input logic [2:0] op);
      return (op == OP_UPDATE) || (op == OP_CONGRUE);
   endfunction

   // Selector used for the first step of each legal opcode
   function automatic logic [7:0] first_selector(input logic [2:0] op);
      logic [7:0] sel;
      case (op)
         OP_UPDATE:  sel = SEL_MARK_AVAIL;
         OP_LOOKUP:  sel = SEL_LOOKUP;
         OP_ENCODE:  sel = SEL_ENCODE;
         OP_CONGRUE: sel = SEL_CONGRUE_UP;
         OP_ENRANK:  sel = SEL_ENRANK;
         default:    sel = SEL_IDLE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/esfa_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// esfa_op_sequencer_if
// Bundles the three sides of the sequencer: the command handshake
// (cmd_*), the broadcast bus to the cell array plus its reduced result
// (cell_*, arr_*), and the response handshake (rsp_*).
//   slave  : the sequencer's view (takes commands, drives cells/responses)
//   master : the surrounding system (issues commands, answers with arr_*,
//            consumes responses)
// ---------------------------------------------------------------------------
interface esfa_op_sequencer_if
   import esfa_pkg::*;
();

   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [DATA_W-1:0] cmd_handle;
   logic [DATA_W-1:0] cmd_index;
   logic [DATA_W-1:0] cmd_value;
   logic [DATA_W-1:0] cmd_metadata;
   logic              cmd_is_metadata;

   logic [DATA_W-1:0] cell_selector;
   logic              cell_will_write;
   logic [DATA_W-1:0] cell_handle;
   logic [DATA_W-1:0] cell_inserted_index;
   logic [DATA_W-1:0] cell_inserted_value;
   logic [DATA_W-1:0] cell_metadata;
   logic              cell_is_metadata;

   logic              arr_bool;
   logic [DATA_W-1:0] arr_value;
   logic [DATA_W-1:0] arr_context;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_bool;
   logic [DATA_W-1:0] rsp_value;
   logic [DATA_W-1:0] rsp_context;

   modport slave (
      input  cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value,
             cmd_metadata, cmd_is_metadata,
      output cmd_ready,
      output cell_selector, cell_will_write, cell_handle,
             cell_inserted_index, cell_inserted_value, cell_metadata,
             cell_is_metadata,
      input  arr_bool, arr_value, arr_context,
      output rsp_valid, rsp_bool, rsp_value, rsp_context,
      input  rsp_ready
   );

   modport master (
      output cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value,
             cmd_metadata, cmd_is_metadata,
      input  cmd_ready,
      input  cell_selector, cell_will_write, cell_handle,
             cell_inserted_index, cell_inserted_value, cell_metadata,
             cell_is_metadata,
      output arr_bool, arr_value, arr_context,
      input  rsp_valid, rsp_bool, rsp_value, rsp_context,
      output rsp_ready
   );

endinterface

// File: rtl/esfa_op_sequencer.sv
// ---------------------------------------------------------------------------
// esfa_op_sequencer
// Takes one ESFA command at a time and expands it into one or two selector
// steps broadcast to the MemoryCell array, samples the reduced array result
// one cycle after each step, and returns a single response per command.
//   clk   : rising-edge clock shared with the cell array
//   reset : synchronous, active-high; drops any command in flight
//   bus   : esfa_op_sequencer_if.slave (cmd_*, cell_*, arr_*, rsp_*)
// Every output is a flop; the selector is SEL_IDLE and will_write is low
// outside the ISSUE states.
// ---------------------------------------------------------------------------
module esfa_op_sequencer
   import esfa_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   esfa_op_sequencer_if.slave  bus
);

   state_t            state_q, state_d;

   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] handle_q, handle_d;
   logic [DATA_W-1:0] index_q, index_d;
   logic [DATA_W-1:0] value_q, value_d;
   logic [DATA_W-1:0] meta_q, meta_d;
   logic              is_meta_q, is_meta_d;

   logic              cmd_ready_q, cmd_ready_d;

   logic [DATA_W-1:0] cell_sel_q, cell_sel_d;
   logic              cell_ww_q, cell_ww_d;
   logic [DATA_W-1:0] cell_handle_q, cell_handle_d;
   logic [DATA_W-1:0] cell_index_q, cell_index_d;
   logic [DATA_W-1:0] cell_value_q, cell_value_d;
   logic [DATA_W-1:0] cell_meta_q, cell_meta_d;
   logic              cell_is_meta_q, cell_is_meta_d;

   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_bool_q, rsp_bool_d;
   logic [DATA_W-1:0] rsp_value_q, rsp_value_d;
   logic [DATA_W-1:0] rsp_ctx_q, rsp_ctx_d;

   logic              accept;
   logic              update_abort;

   assign accept       = bus.cmd_valid && cmd_ready_q;
   // markAvailableCell found no free cell: the array is full
   assign update_abort = (op_q == OP_UPDATE) && !bus.arr_bool;

   // Next-state and next-output logic.  The cell_* flops are loaded on the
   // edge that enters an ISSUE state, so the step is visible to the cells for
   // exactly that one cycle; every other cycle falls back to SEL_IDLE with
   // will_write low.  Step-1 operands come straight from the command bus
   // because the command register is being loaded on that same edge.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      handle_d       = handle_q;
      index_d        = index_q;
      value_d        = value_q;
      meta_d         = meta_q;
      is_meta_d      = is_meta_q;
      cell_sel_d     = SEL_IDLE;
      cell_ww_d      = 1'b0;
      cell_handle_d  = cell_handle_q;
      cell_index_d   = cell_index_q;
      cell_value_d   = cell_value_q;
      cell_meta_d    = cell_meta_q;
      cell_is_meta_d = cell_is_meta_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_bool_d     = rsp_bool_q;
      rsp_value_d    = rsp_value_q;
      rsp_ctx_d      = rsp_ctx_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d      = bus.cmd_op;
               handle_d  = bus.cmd_handle;
               index_d   = bus.cmd_index;
               value_d   = bus.cmd_value;
               meta_d    = bus.cmd_metadata;
               is_meta_d = bus.cmd_is_metadata;
               if (is_legal_op(bus.cmd_op)) begin
                  state_d        = ST_ISSUE1;
                  cell_sel_d     = first_selector(bus.cmd_op);
                  cell_ww_d      = (bus.cmd_op == OP_CONGRUE);
                  cell_handle_d  = bus.cmd_handle;
                  cell_index_d   = bus.cmd_index;
                  cell_value_d   = bus.cmd_value;
                  cell_meta_d    = bus.cmd_metadata;
                  cell_is_meta_d = bus.cmd_is_metadata;
               end else begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_bool_d  = 1'b0;
                  rsp_value_d = '0;
                  rsp_ctx_d   = CTX_FAIL;
               end
            end
         end

         ST_ISSUE1: state_d = ST_WAIT1;

         ST_WAIT1: begin
            if (is_two_step(op_q) && !update_abort) begin
               state_d        = ST_ISSUE2;
               cell_ww_d      = 1'b1;
               cell_handle_d  = handle_q;
               cell_index_d   = index_q;
               cell_value_d   = value_q;
               if (op_q == OP_UPDATE) begin
                  // The free cell's context becomes the metadata to write
                  cell_sel_d     = SEL_UPDATE;
                  cell_meta_d    = bus.arr_context;
                  cell_is_meta_d = 1'b1;
               end else begin
                  cell_sel_d     = SEL_CONGRUE_DOWN;
                  cell_meta_d    = meta_q;
                  cell_is_meta_d = is_meta_q;
               end
            end else begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               if (update_abort) begin
                  rsp_bool_d  = 1'b0;
                  rsp_value_d = '0;
                  rsp_ctx_d   = CTX_FAIL;
               end else begin
                  rsp_bool_d  = bus.arr_bool;
                  rsp_value_d = bus.arr_value;
                  rsp_ctx_d   = bus.arr_context;
               end
            end
         end

         ST_ISSUE2: state_d = ST_WAIT2;

         ST_WAIT2: begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_bool_d  = bus.arr_bool;
            rsp_value_d = bus.arr_value;
            rsp_ctx_d   = bus.arr_context;
         end

         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Registered ready: high exactly while the FSM sits in IDLE
      cmd_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers.  Reset clears everything, so cmd_ready is
   // low while reset is held and rises on the first clock after it drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         op_q           <= '0;
         handle_q       <= '0;
         index_q        <= '0;
         value_q        <= '0;
         meta_q         <= '0;
         is_meta_q      <= 1'b0;
         cmd_ready_q    <= 1'b0;
         cell_sel_q     <= SEL_IDLE;
         cell_ww_q      <= 1'b0;
         cell_handle_q  <= '0;
         cell_index_q   <= '0;
         cell_value_q   <= '0;
         cell_meta_q    <= '0;
         cell_is_meta_q <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_bool_q     <= 1'b0;
         rsp_value_q    <= '0;
         rsp_ctx_q      <= '0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         handle_q       <= handle_d;
         index_q        <= index_d;
         value_q        <= value_d;
         meta_q         <= meta_d;
         is_meta_q      <= is_meta_d;
         cmd_ready_q    <= cmd_ready_d;
         cell_sel_q     <= cell_sel_d;
         cell_ww_q      <= cell_ww_d;
         cell_handle_q  <= cell_handle_d;
         cell_index_q   <= cell_index_d;
         cell_value_q   <= cell_value_d;
         cell_meta_q    <= cell_meta_d;
         cell_is_meta_q <= cell_is_meta_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_bool_q     <= rsp_bool_d;
         rsp_value_q    <= rsp_value_d;
         rsp_ctx_q      <= rsp_ctx_d;
      end
   end

   assign bus.cmd_ready           = cmd_ready_q;
   assign bus.cell_selector       = cell_sel_q;
   assign bus.cell_will_write     = cell_ww_q;
   assign bus.cell_handle         = cell_handle_q;
   assign bus.cell_inserted_index = cell_index_q;
   assign bus.cell_inserted_value = cell_value_q;
   assign bus.cell_metadata       = cell_meta_q;
   assign bus.cell_is_metadata    = cell_is_meta_q;
   assign bus.rsp_valid           = rsp_valid_q;
   assign bus.rsp_bool            = rsp_bool_q;
   assign bus.rsp_value           = rsp_value_q;
   assign bus.rsp_context         = rsp_ctx_q;

endmodule

// File: tb/tb_esfa_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_esfa_op_sequencer
// Drives ESFA commands into the sequencer, stands in for the cell array with
// a stub that answers each issued step with (random or forced) bool/value/
// context, and compares the observed step trace, response and latency with
// a command-level reference model.
// ---------------------------------------------------------------------------
module tb_esfa_op_sequencer;

   typedef struct packed {
      logic [7:0] sel;
      logic       ww;
      logic [7:0] handle;
      logic [7:0] index;
      logic [7:0] value;
      logic [7:0] meta;
      logic       isMeta;
   } step_t;

   typedef struct packed {
      logic       b;
      logic [7:0] v;
      logic [7:0] c;
   } arr_t;

   logic clk = 1'b0;
   logic reset;
   int   cycleCount = 0;
   int   checkCount = 0;
   int   errorCount = 0;

   step_t stepQ[$];
   int    stepCycleQ[$];
   arr_t  stubQ[$];
   bit    idleWriteSeen;
   bit    arrHold;
   int    stubBoolMode;   // 0 random, 1 always found, 2 never found
   bit    useForced;
   arr_t  forcedArr;

   esfa_op_sequencer_if bus();

   esfa_op_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock and a cycle counter used for latency measurement
   always #5 clk = ~clk;
   always @(posedge clk) cycleCount++;

   // Safety net so the run always terminates
   initial begin
      #400000;
      $display("[TB] FAIL globalTimeout observed=running expected=finished");
      $fatal(1, "[TB] global timeout");
   end

   // Cell-array stub and step monitor.  Each non-idle selector is logged,
   // and the stub answer for that step is driven during the ISSUE cycle and
   // held through WAIT; at any other time arr_* carries junk so a response
   // sampled in the wrong cycle shows up.
   always @(negedge clk) begin
      arr_t r;
      if (bus.cell_selector != 8'hFF) begin
         stepQ.push_back({bus.cell_selector, bus.cell_will_write, bus.cell_handle,
                          bus.cell_inserted_index, bus.cell_inserted_value,
                          bus.cell_metadata, bus.cell_is_metadata});
         stepCycleQ.push_back(cycleCount);
         if (useForced) r = forcedArr;
         else begin
            r.b = (stubBoolMode == 0) ? 1'($urandom_range(0, 1)) : (stubBoolMode == 1);
            r.v = 8'($urandom);
            r.c = 8'($urandom);
         end
         stubQ.push_back(r);
         bus.arr_bool    = r.b;
         bus.arr_value   = r.v;
         bus.arr_context = r.c;
         arrHold = 1'b1;
      end else begin
         if (bus.cell_will_write) idleWriteSeen = 1'b1;
         if (arrHold) arrHold = 1'b0;
         else begin
            bus.arr_bool    = 1'($urandom_range(0, 1));
            bus.arr_value   = 8'($urandom);
            bus.arr_context = 8'($urandom);
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic step_t mkStep(input logic [7:0] sel, input logic ww,
                                    input logic [7:0] h, input logic [7:0] i,
                                    input logic [7:0] v, input logic [7:0] m,
                                    input logic im);
      return {sel, ww, h, i, v, m, im};
   endfunction

   // Issue one command, wait for its response, compare against the model,
   // hold rsp_ready low for holdCycles and then complete the handshake.
   task automatic applyStimulus(input logic [2:0] op, input logic [7:0] h,
                                input logic [7:0] i, input logic [7:0] v,
                                input logic [7:0] m, input logic im,
                                input int holdCycles);
      int      waitCount;
      int      acceptCycle;
      int      expLat;
      step_t   expSteps[$];
      arr_t    s0, s1;
      logic [16:0] expRsp, snap;

      @(negedge clk);
      stepQ.delete();
      stepCycleQ.delete();
      stubQ.delete();
      idleWriteSeen = 1'b0;
      bus.cmd_op = op;
      bus.cmd_handle = h;
      bus.cmd_index = i;
      bus.cmd_value = v;
      bus.cmd_metadata = m;
      bus.cmd_is_metadata = im;
      bus.cmd_valid = 1'b1;
      waitCount = 0;
      while (!bus.cmd_ready && waitCount < 20) begin
         @(negedge clk);
         waitCount++;
      end
      if (!bus.cmd_ready) begin
         checkOutput("acceptTimeout", 0, 1);
         bus.cmd_valid = 1'b0;
         return;
      end
      acceptCycle = cycleCount;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      // Scramble the command bus: the sequencer must use its latched copy
      bus.cmd_op = 3'($urandom);
      bus.cmd_handle = 8'($urandom);
      bus.cmd_index = 8'($urandom);
      bus.cmd_value = 8'($urandom);
      bus.cmd_metadata = 8'($urandom);
      bus.cmd_is_metadata = 1'($urandom);
      waitCount = 0;
      while (!bus.rsp_valid && waitCount < 20) begin
         @(negedge clk);
         waitCount++;
      end
      if (!bus.rsp_valid) begin
         checkOutput("rspTimeout", 0, 1);
         return;
      end

      // Reference model: expected steps, response and latency per opcode
      s0 = (stubQ.size() > 0) ? stubQ[0] : '0;
      s1 = (stubQ.size() > 1) ? stubQ[1] : '0;
      case (op)
         3'd0: begin
            expSteps.push_back(mkStep(8'd5, 1'b0, h, i, v, m, im));
            if (stubQ.size() > 0 && s0.b) begin
               expSteps.push_back(mkStep(8'd0, 1'b1, h, i, v, s0.c, 1'b1));
               expRsp = s1;
               expLat = 5;
            end else begin
               expRsp = {1'b0, 8'h00, 8'hFF};
               expLat = 3;
            end
         end
         3'd1, 3'd2, 3'd4: begin
            expSteps.push_back(mkStep((op == 3'd1) ? 8'd1 : (op == 3'd2) ? 8'd2 : 8'd6,
                                      1'b0, h, i, v, m, im));
            expRsp = s0;
            expLat = 3;
         end
         3'd3: begin
            expSteps.push_back(mkStep(8'd3, 1'b1, h, i, v, m, im));
            expSteps.push_back(mkStep(8'd4, 1'b1, h, i, v, m, im));
            expRsp = s1;
            expLat = 5;
         end
         default: begin
            expRsp = {1'b0, 8'h00, 8'hFF};
            expLat = 1;
         end
      endcase

      checkOutput($sformatf("latency op%0d", op), 64'(cycleCount - acceptCycle), 64'(expLat));
      checkOutput($sformatf("stepCount op%0d", op), 64'(stepQ.size()), 64'(expSteps.size()));
      for (int k = 0; k < expSteps.size() && k < stepQ.size(); k++)
         checkOutput($sformatf("step%0d op%0d", k, op), 64'(stepQ[k]), 64'(expSteps[k]));
      if (expSteps.size() == 2 && stepCycleQ.size() == 2)
         checkOutput("stepGap", 64'(stepCycleQ[1] - stepCycleQ[0]), 64'd2);
      checkOutput($sformatf("rsp op%0d", op),
                  {47'd0, bus.rsp_bool, bus.rsp_value, bus.rsp_context}, {47'd0, expRsp});
      checkOutput("idleWrite", 64'(idleWriteSeen), 64'd0);

      snap = {bus.rsp_bool, bus.rsp_value, bus.rsp_context};
      for (int k = 0; k < holdCycles; k++) begin
         @(negedge clk);
         checkOutput("rspHold", {46'd0, bus.rsp_valid, bus.rsp_bool, bus.rsp_value,
                     bus.rsp_context}, {46'd0, 1'b1, snap});
         checkOutput("readyDuringRsp", 64'(bus.cmd_ready), 64'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      checkOutput("rspAfterHandshake", 64'(bus.rsp_valid), 64'd0);
      checkOutput("readyAfterHandshake", 64'(bus.cmd_ready), 64'd1);
   endtask

   // Reset asserted while an UPDATE sits in WAIT1: the command is dropped
   task automatic testResetMidCommand();
      int waitCount;
      @(negedge clk);
      stepQ.delete();
      stepCycleQ.delete();
      stubQ.delete();
      stubBoolMode = 1;
      bus.cmd_op = 3'd0;
      bus.cmd_handle = 8'h11;
      bus.cmd_index = 8'h22;
      bus.cmd_value = 8'h33;
      bus.cmd_metadata = 8'h44;
      bus.cmd_is_metadata = 1'b0;
      bus.cmd_valid = 1'b1;
      waitCount = 0;
      while (!bus.cmd_ready && waitCount < 20) begin
         @(negedge clk);
         waitCount++;
      end
      checkOutput("resetAccept", 64'(bus.cmd_ready), 64'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      checkOutput("resetIssue1Sel", 64'(bus.cell_selector), 64'd5);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("resetSel", {55'd0, bus.cell_selector, bus.cell_will_write},
                  {55'd0, 8'hFF, 1'b0});
      checkOutput("resetRspValid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("resetReadyLow", 64'(bus.cmd_ready), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("resetReadyHigh", 64'(bus.cmd_ready), 64'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput("resetDropped", {62'd0, bus.rsp_valid, (bus.cell_selector != 8'hFF)},
                     64'd0);
      end
      stubBoolMode = 0;
   endtask

   initial begin
      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = '0;
      bus.cmd_handle = '0;
      bus.cmd_index = '0;
      bus.cmd_value = '0;
      bus.cmd_metadata = '0;
      bus.cmd_is_metadata = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.arr_bool = 1'b0;
      bus.arr_value = '0;
      bus.arr_context = '0;
      stubBoolMode = 0;
      useForced = 1'b0;
      forcedArr = '0;
      arrHold = 1'b0;
      idleWriteSeen = 1'b0;

      @(negedge clk);
      @(negedge clk);
      checkOutput("resetReady", 64'(bus.cmd_ready), 64'd0);
      checkOutput("resetRsp", {46'd0, bus.rsp_valid, bus.rsp_bool, bus.rsp_value,
                  bus.rsp_context}, 64'd0);
      checkOutput("resetCell", {22'd0, bus.cell_selector, bus.cell_will_write,
                  bus.cell_handle, bus.cell_inserted_index, bus.cell_inserted_value,
                  bus.cell_metadata, bus.cell_is_metadata}, {22'd0, 8'hFF, 34'd0});
      reset = 1'b0;
      @(negedge clk);
      checkOutput("readyAfterReset", 64'(bus.cmd_ready), 64'd1);

      $display("[TB] directed: LOOKUP handle 03");
      useForced = 1'b1;
      forcedArr = {1'b1, 8'h2A, 8'h05};
      applyStimulus(3'd1, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 0);
      useForced = 1'b0;

      $display("[TB] directed: UPDATE with a free cell");
      stubBoolMode = 1;
      applyStimulus(3'd0, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 1);

      $display("[TB] directed: UPDATE into a full array");
      stubBoolMode = 2;
      applyStimulus(3'd0, 8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 0);
      stubBoolMode = 0;

      $display("[TB] directed: CONGRUE");
      applyStimulus(3'd3, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1, 2);

      $display("[TB] directed: illegal opcode 7 with held response");
      applyStimulus(3'd7, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 4);

      $display("[TB] directed: reset in WAIT1 then LOOKUP");
      testResetMidCommand();
      applyStimulus(3'd1, 8'h55, 8'h66, 8'h77, 8'h88, 1'b1, 0);

      $display("[TB] randomized commands");
      for (int n = 0; n < 60; n++) begin
         applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                       8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
